// File: rtl/pe_pkg.sv
// Shared constants and fixed-point helpers for the weight-stationary PE family.
// Helpers work at a fixed MAX_W-bit internal width. Every PE variant must keep
// 2*DW + 1 < MAX_W and PSUM_W + 1 < MAX_W so that none of the intermediate
// arithmetic can overflow.
package pe_pkg;

  // Default operand and accumulator geometry: Q8.8 operands, 32-bit partial sums.
  localparam int DW_DEF     = 16;
  localparam int FRAC_DEF   = 8;
  localparam int PSUM_W_DEF = 32;

  // Internal working width for rounding and saturation arithmetic.
  localparam int MAX_W = 64;

  // Largest value representable in a w-bit signed partial sum.
  function automatic logic signed [MAX_W-1:0] psum_max(input int w);
    logic signed [MAX_W-1:0] one;
    one = MAX_W'(1);
    return (one <<< (w - 1)) - one;
  endfunction

  // Smallest value representable in a w-bit signed partial sum.
  function automatic logic signed [MAX_W-1:0] psum_min(input int w);
    logic signed [MAX_W-1:0] one;
    one = MAX_W'(1);
    return -(one <<< (w - 1));
  endfunction

  // Drops frac fractional bits from a full-precision product.
  // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
  function automatic logic signed [MAX_W-1:0] round_shift(
    input logic signed [MAX_W-1:0] prod,
    input int                      frac
  );
    logic signed [MAX_W-1:0] half;
    half = MAX_W'(1) <<< (frac - 1);
    return (prod + half) >>> frac;
  endfunction

endpackage : pe_pkg

// File: rtl/fxp_mac_sat.sv
// Combinational fixed-point multiply-accumulate with saturation.
//   sum = clamp(round(act * w >>> FRAC) + psum)
// The operands and psum are signed two's complement. Both share the same FRAC
// scaling. sat_hit flags that a clamp was applied this evaluation.
module fxp_mac_sat
  import pe_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int PSUM_W = PSUM_W_DEF
) (
  input  logic [DW-1:0]     act,
  input  logic [DW-1:0]     w,
  input  logic [PSUM_W-1:0] psum,
  output logic [PSUM_W-1:0] sum,
  output logic              sat_hit
);

  // Clamp bounds of the partial-sum format. These are elaboration-time constants.
  localparam logic signed [MAX_W-1:0] PSUM_HI = psum_max(PSUM_W);
  localparam logic signed [MAX_W-1:0] PSUM_LO = psum_min(PSUM_W);

  logic signed [2*DW-1:0]  prod;
  logic signed [MAX_W-1:0] prod_ext;
  logic signed [MAX_W-1:0] rnd;
  logic signed [MAX_W-1:0] psum_ext;
  logic signed [MAX_W-1:0] sum_ext;

  // Compute the full-precision product. A signed size cast sign-extends it into
  // the working width.
  assign prod     = $signed(act) * $signed(w);
  assign prod_ext = MAX_W'(prod);
  assign psum_ext = MAX_W'($signed(psum));

  // Rescale to the psum's FRAC. The add cannot overflow MAX_W because the
  // package width limits are respected.
  assign rnd      = round_shift(prod_ext, FRAC);
  assign sum_ext  = rnd + psum_ext;

  // Saturate the wide sum into PSUM_W bits and report when a clamp was applied.
  always_comb begin
    // NOTE: outputs get a default before any branch so no path leaves them
    // unassigned; a missing default here would infer a latch.
    sum     = sum_ext[PSUM_W-1:0];
    sat_hit = 1'b0;
    if (sum_ext > PSUM_HI) begin
      sum     = PSUM_HI[PSUM_W-1:0];
      sat_hit = 1'b1;
    end else if (sum_ext < PSUM_LO) begin
      sum     = PSUM_LO[PSUM_W-1:0];
      sat_hit = 1'b1;
    end
  end

endmodule : fxp_mac_sat

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with a double-buffered weight.
// Activations move east and partial sums move south, each through one register.
// Weights shift south through the shadow chain. Asserting w_swap promotes the
// shadow weight to the active weight in one cycle. That lets the next filter
// stream in while the current filter is still computing.
module pe_ws_dbuf
  import pe_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int PSUM_W = PSUM_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DW-1:0]     act_in,
  input  logic              act_vld_in,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic [DW-1:0]     w_in,
  input  logic              w_load_in,
  input  logic              w_swap_in,
  output logic [DW-1:0]     act_out,
  output logic              act_vld_out,
  output logic [PSUM_W-1:0] psum_out,
  output logic [DW-1:0]     w_out,
  output logic              w_load_out,
  output logic              w_swap_out,
  output logic              sat
);

  // Forwarded data and control, plus the accumulator output.
  logic [DW-1:0]     act_q;
  logic              act_vld_q;
  logic [PSUM_W-1:0] psum_q;
  logic              w_load_q;
  logic              w_swap_q;
  logic              sat_q;

  // Weight double buffer.
  logic [DW-1:0]     w_act_q;
  logic [DW-1:0]     shadow_q;
  logic              shadow_vld_q;

  // Signals from the MAC datapath.
  logic [PSUM_W-1:0] mac_sum;
  logic              mac_sat;
  logic              swap_take;

  // A swap request that arrives with no fresh shadow weight is ignored for the
  // local weight, so a stray swap cannot promote stale data.
  assign swap_take = w_swap_in & shadow_vld_q;

  fxp_mac_sat #(
    .DW     (DW),
    .FRAC   (FRAC),
    .PSUM_W (PSUM_W)
  ) u_mac (
    .act     (act_in),
    .w       (w_act_q),
    .psum    (psum_in),
    .sum     (mac_sum),
    .sat_hit (mac_sat)
  );

  // Forwarding registers, accumulator, and sticky saturation flag.
  // clr outranks every other update in this block.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is assigned with <= so that every register in this block
    // samples pre-edge values, regardless of statement order.
    if (!rst_n) begin
      act_q     <= '0;
      act_vld_q <= 1'b0;
      psum_q    <= '0;
      w_load_q  <= 1'b0;
      w_swap_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else if (clr) begin
      act_q     <= '0;
      act_vld_q <= 1'b0;
      psum_q    <= '0;
      w_load_q  <= 1'b0;
      w_swap_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      act_q     <= act_in;
      act_vld_q <= act_vld_in;
      w_load_q  <= w_load_in;
      w_swap_q  <= w_swap_in;
      if (act_vld_in) begin
        psum_q <= mac_sum;
        if (mac_sat) begin
          sat_q <= 1'b1;
        end
      end else begin
        psum_q <= psum_in;
      end
    end
  end

  // Weight shadow chain and swap. This block ignores clr on purpose: the loaded
  // filter must survive a clear of the data path.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the weight registers are datapath state but are still reset, so
    // the cells of a freshly reset array compute with a known zero weight.
    if (!rst_n) begin
      w_act_q      <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
    end else begin
      if (swap_take) begin
        w_act_q <= shadow_q;
      end
      if (w_load_in) begin
        shadow_q     <= w_in;
        shadow_vld_q <= 1'b1;
      end else if (swap_take) begin
        shadow_vld_q <= 1'b0;
      end
    end
  end

  assign act_out     = act_q;
  assign act_vld_out = act_vld_q;
  assign psum_out    = psum_q;
  assign w_out       = shadow_q;
  assign w_load_out  = w_load_q;
  assign w_swap_out  = w_swap_q;
  assign sat         = sat_q;

endmodule : pe_ws_dbuf

// File: tb/tb_pe_ws_dbuf.sv
// Self-checking bench for pe_ws_dbuf, with DW=16, FRAC=8 and PSUM_W=32.
// Each driven cycle pushes the psum_out/sat values expected after the next
// clock edge. A monitor pops one entry per edge and compares it.
// Forwarding and reset behaviour are checked inline in the scenario tasks.
module tb_pe_ws_dbuf;

  localparam int DW     = 16;
  localparam int FRAC   = 8;
  localparam int PSUM_W = 32;

  typedef struct {
    logic [PSUM_W-1:0] psum;
    logic              sat;
    string             name;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [DW-1:0]     act_in;
  logic              act_vld_in;
  logic [PSUM_W-1:0] psum_in;
  logic [DW-1:0]     w_in;
  logic              w_load_in;
  logic              w_swap_in;
  logic [DW-1:0]     act_out;
  logic              act_vld_out;
  logic [PSUM_W-1:0] psum_out;
  logic [DW-1:0]     w_out;
  logic              w_load_out;
  logic              w_swap_out;
  logic              sat;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pe_ws_dbuf #(
    .DW     (DW),
    .FRAC   (FRAC),
    .PSUM_W (PSUM_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .act_in      (act_in),
    .act_vld_in  (act_vld_in),
    .psum_in     (psum_in),
    .w_in        (w_in),
    .w_load_in   (w_load_in),
    .w_swap_in   (w_swap_in),
    .act_out     (act_out),
    .act_vld_out (act_vld_out),
    .psum_out    (psum_out),
    .w_out       (w_out),
    .w_load_out  (w_load_out),
    .w_swap_out  (w_swap_out),
    .sat         (sat)
  );

  // Scoreboard monitor: after each edge, compare one expected entry if any is queued.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        n_checks++;
        if (psum_out !== mon_e.psum || sat !== mon_e.sat)
          $display("FAIL %s: got psum_out=%h sat=%b, expected psum_out=%h sat=%b",
                   mon_e.name, psum_out, sat, mon_e.psum, mon_e.sat);
        else
          n_pass++;
      end
    end
  end

  // Drive one cycle of stimulus at the falling edge and queue what the next edge must produce.
  task automatic drive(input logic [DW-1:0] a, input logic av, input logic [PSUM_W-1:0] p,
                       input logic [DW-1:0] w, input logic ld, input logic sw, input logic c,
                       input logic [PSUM_W-1:0] ep, input logic es, input string nm);
    exp_t e;
    @(negedge clk);
    act_in     = a;
    act_vld_in = av;
    psum_in    = p;
    w_in       = w;
    w_load_in  = ld;
    w_swap_in  = sw;
    clr        = c;
    e.psum = ep;
    e.sat  = es;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; act_in = '0; act_vld_in = 1'b0; psum_in = '0;
    w_in = '0; w_load_in = 1'b0; w_swap_in = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({act_out, act_vld_out, psum_out, w_out, w_load_out, w_swap_out, sat} !== '0)
      $display("FAIL reset_outputs: got act=%h vld=%b psum=%h w=%h ld=%b sw=%b sat=%b, expected all 0",
               act_out, act_vld_out, psum_out, w_out, w_load_out, w_swap_out, sat);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_mac();
    drive(16'h0000, 0, 32'h0, 16'h0180, 1, 0, 0, 32'h0, 0, "basic_load");
    settle();
    n_checks++;
    if (w_out !== 16'h0180 || w_load_out !== 1'b1)
      $display("FAIL basic_w_chain: got w_out=%h w_load_out=%b, expected 0180 1", w_out, w_load_out);
    else n_pass++;
    drive(16'h0000, 0, 32'h0, 16'h0000, 0, 1, 0, 32'h0, 0, "basic_swap");
    drive(16'h0200, 1, 32'h100, 16'h0000, 0, 0, 0, 32'h400, 0, "basic_mac");
    drive(16'h0000, 0, 32'h0, 16'h0000, 0, 0, 0, 32'h0, 0, "basic_idle");
  endtask

  task automatic test_rounding();
    drive(16'h0000, 0, 32'h0, 16'h0080, 1, 0, 0, 32'h0, 0, "rnd_load");
    drive(16'h0000, 0, 32'h0, 16'h0000, 0, 1, 0, 32'h0, 0, "rnd_swap");
    drive(16'h0001, 1, 32'h0, 16'h0000, 0, 0, 0, 32'h1, 0, "rnd_pos_half");
    drive(16'hFFFF, 1, 32'h0, 16'h0000, 0, 0, 0, 32'h0, 0, "rnd_neg_half");
    drive(16'hFFFE, 1, 32'h0, 16'h0000, 0, 0, 0, 32'hFFFFFFFF, 0, "rnd_neg_one");
    drive(16'h0003, 1, 32'h10, 16'h0000, 0, 0, 0, 32'h12, 0, "rnd_one_half_acc");
  endtask

  task automatic test_valid_chain();
    drive(16'h7FFF, 0, 32'h1234, 16'h0ABC, 1, 0, 0, 32'h1234, 0, "vld_passthru");
    settle();
    n_checks++;
    if (act_out !== 16'h7FFF || act_vld_out !== 1'b0)
      $display("FAIL act_forward: got act_out=%h vld=%b, expected 7fff 0", act_out, act_vld_out);
    else n_pass++;
    n_checks++;
    if (w_out !== 16'h0ABC || w_load_out !== 1'b1 || w_swap_out !== 1'b0)
      $display("FAIL load_forward: got w_out=%h ld=%b sw=%b, expected 0abc 1 0", w_out, w_load_out, w_swap_out);
    else n_pass++;
    drive(16'h0005, 1, 32'h0, 16'h0000, 0, 1, 0, 32'h3, 0, "swap_cycle_old_w");
    settle();
    n_checks++;
    if (w_swap_out !== 1'b1 || w_load_out !== 1'b0 || w_out !== 16'h0ABC || act_vld_out !== 1'b1)
      $display("FAIL swap_forward: got sw=%b ld=%b w_out=%h vld=%b, expected 1 0 0abc 1",
               w_swap_out, w_load_out, w_out, act_vld_out);
    else n_pass++;
    drive(16'h0000, 0, 32'h0, 16'h0000, 0, 0, 0, 32'h0, 0, "chain_idle");
  endtask

  task automatic test_saturation();
    drive(16'h0000, 0, 32'h0, 16'h0100, 1, 0, 0, 32'h0, 0, "sat_load");
    drive(16'h0000, 0, 32'h0, 16'h0000, 0, 1, 0, 32'h0, 0, "sat_swap");
    drive(16'h0100, 1, 32'h7FFFFFFF, 16'h0, 0, 0, 0, 32'h7FFFFFFF, 1, "sat_pos_clamp");
    drive(16'h0100, 1, 32'h0, 16'h0, 0, 0, 0, 32'h100, 1, "sat_sticky");
    drive(16'h0100, 1, 32'h7FFFFEFF, 16'h0, 0, 0, 0, 32'h7FFFFFFF, 1, "sat_exact_max");
    drive(16'h0100, 1, 32'h5, 16'h0, 0, 0, 1, 32'h0, 0, "sat_clr");
    drive(16'hFF00, 1, 32'h80000000, 16'h0, 0, 0, 0, 32'h80000000, 1, "sat_neg_clamp");
    drive(16'h0000, 0, 32'h0, 16'h0, 0, 0, 1, 32'h0, 0, "sat_clr2");
    drive(16'hFF00, 1, 32'h80000100, 16'h0, 0, 0, 0, 32'h80000000, 0, "sat_exact_min");
  endtask

  task automatic test_double_buffer();
    drive(16'h0100, 1, 32'h0, 16'h0300, 1, 0, 0, 32'h100, 0, "dbuf_load_during_mac");
    drive(16'h0100, 1, 32'h0, 16'h0000, 0, 1, 0, 32'h100, 0, "dbuf_swap_cycle");
    drive(16'h0100, 1, 32'h0, 16'h0000, 0, 0, 0, 32'h300, 0, "dbuf_new_weight");
    drive(16'h0100, 1, 32'h0, 16'h0000, 0, 1, 0, 32'h300, 0, "dbuf_stale_swap");
    drive(16'h0100, 1, 32'h0, 16'h0000, 0, 0, 0, 32'h300, 0, "dbuf_stale_kept");
  endtask

  task automatic test_back_to_back();
    drive(16'h0100, 1, 32'h0, 16'h0200, 1, 0, 0, 32'h300, 0, "b2b_load");
    drive(16'h0100, 1, 32'h0, 16'h0040, 1, 1, 0, 32'h300, 0, "b2b_load_swap");
    drive(16'h0100, 1, 32'h0, 16'h0000, 0, 0, 0, 32'h200, 0, "b2b_promoted");
    drive(16'h0100, 1, 32'h0, 16'h0000, 0, 1, 0, 32'h200, 0, "b2b_swap2");
    drive(16'h0100, 1, 32'h0, 16'h0000, 0, 0, 0, 32'h040, 0, "b2b_second_weight");
  endtask

  task automatic test_clr_with_load();
    drive(16'h0100, 1, 32'h9, 16'h0500, 1, 0, 1, 32'h0, 0, "clr_load");
    settle();
    n_checks++;
    if (w_load_out !== 1'b0 || w_out !== 16'h0500 || act_out !== 16'h0)
      $display("FAIL clr_load_fwd: got ld=%b w_out=%h act=%h, expected 0 0500 0000", w_load_out, w_out, act_out);
    else n_pass++;
    drive(16'h0000, 0, 32'h0, 16'h0000, 0, 1, 1, 32'h0, 0, "clr_swap");
    settle();
    n_checks++;
    if (w_swap_out !== 1'b0)
      $display("FAIL clr_swap_fwd: got w_swap_out=%b, expected 0", w_swap_out);
    else n_pass++;
    drive(16'h0100, 1, 32'h0, 16'h0000, 0, 0, 0, 32'h500, 0, "clr_swap_took");
  endtask

  task automatic test_async_reset();
    drive(16'h0100, 1, 32'h7FFFFFFF, 16'h0123, 1, 0, 0, 32'h7FFFFFFF, 1, "ar_pre_sat");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({act_out, act_vld_out, psum_out, w_out, w_load_out, w_swap_out, sat} !== '0)
      $display("FAIL async_reset: got act=%h vld=%b psum=%h w=%h ld=%b sw=%b sat=%b, expected all 0",
               act_out, act_vld_out, psum_out, w_out, w_load_out, w_swap_out, sat);
    else n_pass++;
    act_in = '0; act_vld_in = 1'b0; psum_in = '0; w_in = '0; w_load_in = 1'b0; w_swap_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'h0000, 0, 32'h0, 16'h0000, 0, 1, 0, 32'h0, 0, "ar_swap_noload");
    drive(16'h0100, 1, 32'h55, 16'h0000, 0, 0, 0, 32'h55, 0, "ar_zero_weight");
    drive(16'h7FFF, 1, 32'hFFFFFFF0, 16'h0000, 0, 0, 0, 32'hFFFFFFF0, 0, "ar_zero_weight_neg");
  endtask

  initial begin
    test_reset();
    test_basic_mac();
    test_rounding();
    test_valid_chain();
    test_saturation();
    test_double_buffer();
    test_back_to_back();
    test_clr_with_load();
    test_async_reset();
    @(posedge clk);
    #3;
    n_checks++;
    if (sb.size() !== 0)
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pe_ws_dbuf
